// File: rtl/game_state_ctrl.sv
// Game-flow FSM (READY/PLAY/DEAD) with flap debounce, collision detect and high score.
// Flap pulse lags a clean press by 2+DEB_TICKS ticks; state/collide update one tick after the sampled event; no backpressure.
module game_state_ctrl #(
  parameter int unsigned slot_width   = 60,
  parameter int unsigned slot_height  = 100,
  parameter int unsigned bird_HPos    = 320,
  parameter int unsigned bird_Xwidth  = 34,
  parameter int unsigned bird_Yheight = 24,
  parameter int unsigned screen_H     = 480,
  parameter int unsigned DEB_TICKS    = 5,
  parameter int unsigned DEAD_HOLD    = 500
) (
  input  logic       clk_2ms,
  input  logic       rst_n,
  input  logic       btn_flap,
  input  logic [9:0] pip_X,
  input  logic [8:0] pip_Y,
  input  logic [8:0] bird_Y,
  input  logic [7:0] score,
  output logic [1:0] state,
  output logic       flap,
  output logic       collide,
  output logic [7:0] hi_score
);

  localparam int DW = $clog2(DEB_TICKS + 1);
  localparam int HW = $clog2(DEAD_HOLD + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_TICKS - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(DEAD_HOLD);

  localparam logic [10:0] XO_LO = 11'(bird_HPos - bird_Xwidth);
  localparam logic [10:0] XO_HI = 11'(bird_HPos + slot_width);
  localparam logic [10:0] GAP_H = 11'(slot_height);
  localparam logic [10:0] BIRD_H = 11'(bird_Yheight);
  localparam logic [10:0] GROUND = 11'(screen_H);

  typedef enum logic [1:0] {
    READY   = 2'd0,
    PLAY    = 2'd1,
    DEAD    = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

  state_t          cur_state;
  state_t          nxt_state;
  logic            go_dead;
  logic            sync1;
  logic            sync2;
  logic            db_level;
  logic [DW-1:0]   db_cnt;
  logic [HW-1:0]   hold;
  logic [10:0]     px;
  logic [10:0]     py;
  logic [10:0]     by;
  logic            xo;
  logic            in_gap;
  logic            hit;

  always_ff @(posedge clk_2ms) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      db_level <= 1'b0;
      db_cnt   <= '0;
      flap     <= 1'b0;
    end else begin
      sync1 <= btn_flap;
      sync2 <= sync1;
      flap  <= 1'b0;
      if (sync2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DEB_LAST) begin
        db_level <= ~db_level;
        db_cnt   <= '0;
        flap     <= ~db_level;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Gap-top test is rearranged as by+height >= py so a small pip_Y cannot underflow.
  assign px     = {1'b0, pip_X};
  assign py     = {2'b00, pip_Y};
  assign by     = {2'b00, bird_Y};
  assign xo     = (px > XO_LO) && (px < XO_HI);
  assign in_gap = (by + GAP_H >= py) && (by + BIRD_H <= py);
  assign hit    = (xo && !in_gap) || (by + BIRD_H >= GROUND) || (bird_Y == '0);

  always_comb begin
    nxt_state = cur_state;
    go_dead   = 1'b0;
    case (cur_state)
      READY: if (flap) nxt_state = PLAY;
      PLAY: begin
        if (hit) begin
          nxt_state = DEAD;
          go_dead   = 1'b1;
        end
      end
      DEAD: if (flap && (hold == HOLD_MAX)) nxt_state = READY;
      default: nxt_state = READY;
    endcase
  end

  always_ff @(posedge clk_2ms) begin
    if (!rst_n) begin
      cur_state <= READY;
      hold      <= '0;
      collide   <= 1'b0;
      hi_score  <= '0;
    end else begin
      cur_state <= nxt_state;
      collide   <= go_dead;
      if (go_dead && (score > hi_score)) hi_score <= score;
      if ((cur_state == DEAD) && (nxt_state == DEAD)) begin
        if (hold != HOLD_MAX) hold <= hold + 1'b1;
      end else begin
        hold <= '0;
      end
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl: directed vectors plus randomized run against a reference model.
module tb_game_state_ctrl;

  logic       clk_2ms;
  logic       rst_n;
  logic       btn_flap;
  logic [9:0] pip_X;
  logic [8:0] pip_Y;
  logic [8:0] bird_Y;
  logic [7:0] score;
  logic [1:0] state;
  logic       flap;
  logic       collide;
  logic [7:0] hi_score;

  game_state_ctrl dut (
    .clk_2ms (clk_2ms),
    .rst_n   (rst_n),
    .btn_flap(btn_flap),
    .pip_X   (pip_X),
    .pip_Y   (pip_Y),
    .bird_Y  (bird_Y),
    .score   (score),
    .state   (state),
    .flap    (flap),
    .collide (collide),
    .hi_score(hi_score)
  );

  initial clk_2ms = 1'b0;
  always #5 clk_2ms = ~clk_2ms;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int m_state = 0;
  bit m_flap = 0;
  bit m_collide = 0;
  int m_hi = 0;
  bit m_level = 0;
  int edge_no = 0;
  int dead_since = 0;
  bit btnq[$];
  bit sq[$];

  typedef struct {
    int px;
    int py;
    int by;
    bit hit;
  } vec_t;
  vec_t vecs[12];

  function automatic bit ref_hit(int px, int py, int by);
    bit xo;
    bit gap;
    xo  = (px > 320 - 34) && (px < 320 + 60);
    gap = (by >= py - 100) && (by + 24 <= py);
    return (xo && !gap) || (by + 24 >= 480) || (by == 0);
  endfunction

  task automatic model_edge();
    bit synced;
    bit all_diff;
    edge_no++;
    if (!rst_n) begin
      m_state = 0; m_flap = 0; m_collide = 0; m_hi = 0; m_level = 0;
      btnq.delete(); sq.delete();
      return;
    end
    m_collide = 0;
    case (m_state)
      0: if (m_flap) m_state = 1;
      1: if (ref_hit(int'(pip_X), int'(pip_Y), int'(bird_Y))) begin
           m_state = 2; m_collide = 1; dead_since = edge_no;
           if (int'(score) > m_hi) m_hi = int'(score);
         end
      2: if (m_flap && (edge_no - dead_since) >= 501) m_state = 0;
      default: m_state = 0;
    endcase
    // Button seen by the debouncer is the raw level from two edges earlier.
    btnq.push_back(btn_flap);
    if (btnq.size() > 3) void'(btnq.pop_front());
    synced = (btnq.size() == 3) ? btnq[0] : 1'b0;
    sq.push_back(synced);
    if (sq.size() > 5) void'(sq.pop_front());
    all_diff = (sq.size() == 5);
    foreach (sq[i]) if (sq[i] == m_level) all_diff = 0;
    m_flap = all_diff && !m_level;
    if (all_diff) m_level = !m_level;
  endtask

  task automatic step();
    @(posedge clk_2ms);
    model_edge();
    @(negedge clk_2ms);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string ctx);
    check({ctx, "_state"}, int'(state), m_state);
    check({ctx, "_flap"}, int'(flap), int'(m_flap));
    check({ctx, "_collide"}, int'(collide), int'(m_collide));
    check({ctx, "_hi"}, int'(hi_score), m_hi);
  endtask

  task automatic safe();
    pip_X = 10'd600; pip_Y = 9'd300; bird_Y = 9'd220;
  endtask

  task automatic enter_play();
    safe(); btn_flap = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1; btn_flap = 1'b1;
    for (int i = 0; i < 20 && state != 2'd1; i++) begin
      step(); check_model("enter");
    end
    btn_flap = 1'b0;
    check("enter_play", int'(state), 1);
  endtask

  task automatic die(input int s);
    score = 8'(s); bird_Y = 9'd0;
    step();
    check("die_state", int'(state), 2);
    check("die_collide", int'(collide), 1);
    check_model("die");
    bird_Y = 9'd220;
  endtask

  task automatic recover_to_play();
    for (int k = 1; k <= 530; k++) begin
      btn_flap = ((k >= 494 && k <= 500) || (k >= 510 && k <= 516));
      step();
      check_model("recover");
      if (k == 1) check("collide_pulse_len", int'(collide), 0);
      if (k == 500) check("hold_500_still_dead", int'(state), 2);
      if (k == 501) check("hold_501_ready", int'(state), 0);
    end
    check("recover_play", int'(state), 1);
  endtask

  initial begin
    int nflap;
    vecs[0]  = '{300, 300, 150, 1'b1};
    vecs[1]  = '{300, 300, 220, 1'b0};
    vecs[2]  = '{286, 300,   1, 1'b0};
    vecs[3]  = '{287, 300,   1, 1'b1};
    vecs[4]  = '{600, 300, 456, 1'b1};
    vecs[5]  = '{600, 300, 455, 1'b0};
    vecs[6]  = '{600, 300,   0, 1'b1};
    vecs[7]  = '{379, 300, 276, 1'b0};
    vecs[8]  = '{380, 300, 150, 1'b0};
    vecs[9]  = '{379, 300, 277, 1'b1};
    vecs[10] = '{300,  50,  10, 1'b0};
    vecs[11] = '{300,  50,  27, 1'b1};

    rst_n = 1'b0; btn_flap = 1'b1; score = 8'd0;
    safe();

    // Reset held with the button pressed
    repeat (3) step();
    check("rst_state", int'(state), 0);
    check("rst_flap", int'(flap), 0);
    check("rst_collide", int'(collide), 0);
    check("rst_hi", int'(hi_score), 0);
    check_model("rst");
    rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      check($sformatf("press_lat_t%0d", i), int'(flap), (i == 7) ? 1 : 0);
      check_model("press");
    end
    step();
    check("ready_to_play", int'(state), 1);
    btn_flap = 1'b0;

    // Bouncing button gives exactly one flap
    rst_n = 1'b0; step(); rst_n = 1'b1;
    nflap = 0;
    for (int i = 0; i < 20; i++) begin
      btn_flap = (i % 2 == 0);
      step(); check_model("bounce");
      nflap += int'(flap);
    end
    btn_flap = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step(); check_model("settle");
      nflap += int'(flap);
    end
    check("bounce_flaps", nflap, 1);
    check("bounce_state", int'(state), 1);
    btn_flap = 1'b0;

    // Collision vectors, each applied for one tick in PLAY
    for (int i = 0; i < 12; i++) begin
      enter_play();
      pip_X = 10'(vecs[i].px); pip_Y = 9'(vecs[i].py); bird_Y = 9'(vecs[i].by);
      step();
      check($sformatf("vec%0d_state", i), int'(state), vecs[i].hit ? 2 : 1);
      check($sformatf("vec%0d_collide", i), int'(collide), int'(vecs[i].hit));
      check_model("vec");
    end

    // Early flaps in DEAD are discarded
    enter_play();
    die(5);
    for (int k = 1; k <= 510; k++) begin
      btn_flap = ((k >= 93 && k <= 99) || (k >= 493 && k <= 499));
      step();
      check_model("hold");
      check($sformatf("hold_k%0d", k), int'(state), 2);
    end

    // Flap exactly when the hold completes, then play again
    enter_play();
    die(5);
    recover_to_play();

    // High score tracking
    enter_play();
    die(7);
    check("hi_after_7", int'(hi_score), 7);
    recover_to_play();
    die(3);
    check("hi_after_3", int'(hi_score), 7);
    recover_to_play();
    die(9);
    check("hi_after_9", int'(hi_score), 9);
    recover_to_play();
    rst_n = 1'b0;
    step();
    check("midplay_rst_state", int'(state), 0);
    check("midplay_rst_hi", int'(hi_score), 0);
    check_model("midrst");
    rst_n = 1'b1;

    // Randomized run against the model
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 9) == 0) btn_flap = ~btn_flap;
      rst_n  = ($urandom_range(0, 999) != 0);
      pip_X  = 10'($urandom_range(0, 699));
      pip_Y  = 9'($urandom_range(0, 511));
      bird_Y = 9'($urandom_range(0, 511));
      score  = 8'($urandom_range(0, 255));
      step();
      check_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
